// File: rtl/el2_dbg_cmd_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : el2_dbg_pkg
//  Description : Shared types and constants for the debug-command issue path:
//                FSM state enum, cmderr codes, command types, access sizes.
//  Revision    : 1.0 - initial release
// ============================================================================
package el2_dbg_pkg;

  typedef enum logic [2:0] {
    DBG_IDLE  = 3'd0,
    DBG_CHECK = 3'd1,
    DBG_ISSUE = 3'd2,
    DBG_WAIT  = 3'd3,
    DBG_RESP  = 3'd4
  } el2_dbg_cmd_state_t;

  localparam logic [2:0] CMDERR_NONE   = 3'd0;
  localparam logic [2:0] CMDERR_UNSUP  = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPT = 3'd3;
  localparam logic [2:0] CMDERR_HALT   = 3'd4;

  localparam logic [1:0] DBG_TYPE_GPR  = 2'd0;
  localparam logic [1:0] DBG_TYPE_CSR  = 2'd1;
  localparam logic [1:0] DBG_TYPE_MEM  = 2'd2;
  localparam logic [1:0] DBG_TYPE_RSVD = 2'd3;

  localparam logic [1:0] DBG_SIZE_HALF = 2'd1;
  localparam logic [1:0] DBG_SIZE_WORD = 2'd2;
  localparam logic [1:0] DBG_SIZE_RSVD = 2'd3;

  localparam logic [31:0] GPR_REGNO_BASE = 32'h1000;
  localparam logic [31:0] GPR_REGNO_SPAN = 32'd32;

  // Captured abstract command
  typedef struct packed {
    logic        write;
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } el2_dbg_cmd_t;

endpackage
`default_nettype wire

// File: rtl/el2_dbg_cmd_issue_if.sv
`default_nettype none
// ============================================================================
//  Module      : el2_dbg_cmd_issue_if
//  Description : Request, debug-command and response signals of the debug
//                command issue block. 'master' is the issue block itself,
//                'slave' is the surrounding front end plus core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface el2_dbg_cmd_issue_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        core_halted;
  logic        dbg_cmd_valid;
  logic        dbg_cmd_write;
  logic [1:0]  dbg_cmd_type;
  logic [31:0] dbg_cmd_addr;
  logic [31:0] dbg_cmd_wrdata;
  logic [1:0]  dbg_cmd_size;
  logic        dbg_cmd_done;
  logic        dbg_cmd_fail;
  logic [31:0] dbg_rddata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_cmderr;
  logic [31:0] rsp_rdata;

  modport master (
    input  req_valid, req_write, req_type, req_addr, req_wdata, req_size,
    input  core_halted, dbg_cmd_done, dbg_cmd_fail, dbg_rddata, rsp_ready,
    output req_ready, dbg_cmd_valid, dbg_cmd_write, dbg_cmd_type,
    output dbg_cmd_addr, dbg_cmd_wrdata, dbg_cmd_size,
    output rsp_valid, rsp_cmderr, rsp_rdata
  );

  modport slave (
    output req_valid, req_write, req_type, req_addr, req_wdata, req_size,
    output core_halted, dbg_cmd_done, dbg_cmd_fail, dbg_rddata, rsp_ready,
    input  req_ready, dbg_cmd_valid, dbg_cmd_write, dbg_cmd_type,
    input  dbg_cmd_addr, dbg_cmd_wrdata, dbg_cmd_size,
    input  rsp_valid, rsp_cmderr, rsp_rdata
  );

endinterface
`default_nettype wire

// File: rtl/el2_dbg_cmd_issue_check.sv
`default_nettype none
// ============================================================================
//  Module      : el2_dbg_cmd_check
//  Description : Combinational validator for a captured debug command.
//                Applies the type / halt / regno / CSR range / memory size
//                and alignment rules in priority order.
//  Revision    : 1.0 - initial release
// ============================================================================
module el2_dbg_cmd_check
  import el2_dbg_pkg::*;
(
  input  logic [1:0]  cmd_type,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic        core_halted,
  output logic        chk_err,
  output logic [2:0]  chk_cmderr
);

  logic [31:0] gpr_offset;
  logic        mem_misaligned;

  // Offset from the GPR regno window; wraps high for regnos below the base
  assign gpr_offset = cmd_addr - GPR_REGNO_BASE;

  assign mem_misaligned = (cmd_size == DBG_SIZE_RSVD) ||
                          ((cmd_size == DBG_SIZE_HALF) && cmd_addr[0]) ||
                          ((cmd_size == DBG_SIZE_WORD) && (cmd_addr[1:0] != 2'b00));

  // Priority-ordered legality checks; first failing rule sets the code
  always_comb begin
    chk_err    = 1'b0;
    chk_cmderr = CMDERR_NONE;
    if (cmd_type == DBG_TYPE_RSVD) begin
      chk_err    = 1'b1;
      chk_cmderr = CMDERR_UNSUP;
    end else if (!core_halted) begin
      chk_err    = 1'b1;
      chk_cmderr = CMDERR_HALT;
    end else if ((cmd_type == DBG_TYPE_GPR) && (gpr_offset >= GPR_REGNO_SPAN)) begin
      chk_err    = 1'b1;
      chk_cmderr = CMDERR_UNSUP;
    end else if ((cmd_type == DBG_TYPE_CSR) && (cmd_addr[31:12] != 20'd0)) begin
      chk_err    = 1'b1;
      chk_cmderr = CMDERR_UNSUP;
    end else if ((cmd_type == DBG_TYPE_MEM) && mem_misaligned) begin
      chk_err    = 1'b1;
      chk_cmderr = CMDERR_EXCEPT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/el2_dbg_cmd_issue.sv
`default_nettype none
// ============================================================================
//  Module      : el2_dbg_cmd_issue
//  Description : Debug abstract-command initiator. Accepts one command,
//                validates it, pulses dbg_cmd_* into decode, waits for the
//                core's done/fail and returns cmderr + read data.
//                Optional macro DBG_CMD_TIMEOUT_EN adds a WAIT timeout of
//                TIMEOUT_CYCLES cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module el2_dbg_cmd_issue
  import el2_dbg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic                clk,
  input  logic                rst,
  el2_dbg_cmd_issue_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  el2_dbg_cmd_state_t state_q, state_d;
  el2_dbg_cmd_t       cmd_q, cmd_d;
  logic [2:0]         cmderr_q, cmderr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               chk_err;
  logic [2:0]         chk_cmderr;
  logic               timeout_hit;

`ifdef DBG_CMD_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  el2_dbg_cmd_check u_check (
    .cmd_type    (cmd_q.typ),
    .cmd_addr    (cmd_q.addr),
    .cmd_size    (cmd_q.size),
    .core_halted (bus.core_halted),
    .chk_err     (chk_err),
    .chk_cmderr  (chk_cmderr)
  );

  // Next-state, command capture and response capture
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    cmderr_d = cmderr_q;
    rdata_d  = rdata_q;
`ifdef DBG_CMD_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      DBG_IDLE: begin
        if (bus.req_valid) begin
          cmd_d.write = bus.req_write;
          cmd_d.typ   = bus.req_type;
          cmd_d.addr  = bus.req_addr;
          cmd_d.wdata = bus.req_wdata;
          cmd_d.size  = bus.req_size;
          cmderr_d    = CMDERR_NONE;
          rdata_d     = 32'd0;
          state_d     = DBG_CHECK;
        end
      end
      DBG_CHECK: begin
        if (chk_err) begin
          cmderr_d = chk_cmderr;
          rdata_d  = 32'd0;
          state_d  = DBG_RESP;
        end else begin
          state_d  = DBG_ISSUE;
        end
      end
      DBG_ISSUE: begin
`ifdef DBG_CMD_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = DBG_WAIT;
      end
      DBG_WAIT: begin
`ifdef DBG_CMD_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        // fail outranks a simultaneous done
        if (bus.dbg_cmd_fail) begin
          cmderr_d = CMDERR_EXCEPT;
          rdata_d  = 32'd0;
          state_d  = DBG_RESP;
        end else if (bus.dbg_cmd_done) begin
          cmderr_d = CMDERR_NONE;
          rdata_d  = cmd_q.write ? 32'd0 : bus.dbg_rddata;
          state_d  = DBG_RESP;
        end else if (timeout_hit) begin
          cmderr_d = CMDERR_EXCEPT;
          rdata_d  = 32'd0;
          state_d  = DBG_RESP;
        end
      end
      DBG_RESP: begin
        if (bus.rsp_ready) begin
          state_d = DBG_IDLE;
        end
      end
      default: begin
        state_d = DBG_IDLE;
      end
    endcase
  end

  // State and capture registers; reset abandons any in-flight command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DBG_IDLE;
      cmd_q    <= '0;
      cmderr_q <= CMDERR_NONE;
      rdata_q  <= 32'd0;
`ifdef DBG_CMD_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cmderr_q <= cmderr_d;
      rdata_q  <= rdata_d;
`ifdef DBG_CMD_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Outputs decoded from state; command fields held from ISSUE through WAIT
  always_comb begin
    bus.req_ready      = (state_q == DBG_IDLE);
    bus.dbg_cmd_valid  = (state_q == DBG_ISSUE);
    bus.dbg_cmd_write  = 1'b0;
    bus.dbg_cmd_type   = 2'd0;
    bus.dbg_cmd_addr   = 32'd0;
    bus.dbg_cmd_wrdata = 32'd0;
    bus.dbg_cmd_size   = 2'd0;
    bus.rsp_valid      = (state_q == DBG_RESP);
    bus.rsp_cmderr     = CMDERR_NONE;
    bus.rsp_rdata      = 32'd0;
    if ((state_q == DBG_ISSUE) || (state_q == DBG_WAIT)) begin
      bus.dbg_cmd_write  = cmd_q.write;
      bus.dbg_cmd_type   = cmd_q.typ;
      bus.dbg_cmd_addr   = (cmd_q.typ == DBG_TYPE_GPR) ? {27'd0, cmd_q.addr[4:0]} : cmd_q.addr;
      bus.dbg_cmd_wrdata = cmd_q.wdata;
      bus.dbg_cmd_size   = cmd_q.size;
    end
    if (state_q == DBG_RESP) begin
      bus.rsp_cmderr = cmderr_q;
      bus.rsp_rdata  = rdata_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_el2_dbg_cmd_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_el2_dbg_cmd_issue
//  Description : Scoreboard bench for el2_dbg_cmd_issue: directed and random
//                commands, a core responder and a response monitor.
//                Honours DBG_CMD_TIMEOUT_EN (DUT built with TIMEOUT_CYCLES 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_el2_dbg_cmd_issue;

  localparam int K_DONE = 0;
  localparam int K_FAIL = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;
  localparam int TB_TIMEOUT = 8;

  typedef struct {
    logic        write;
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        halted;
    int          kind;
    int          delay;
    logic [31:0] rddata;
    logic        drop_halt;
  } cmd_s;

  typedef struct {
    logic [2:0]  cmderr;
    logic [31:0] rdata;
  } rsp_s;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   rsp_pushed;
  int   rsp_seen;
  logic core_busy;
  logic force_stall;

  cmd_s issue_q[$];
  rsp_s rsp_q[$];

  el2_dbg_cmd_issue_if bus();

  el2_dbg_cmd_issue #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic abort_run(string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
    finish_run();
  endtask

  // Reference legality rules, written directly from the command semantics
  function automatic logic [2:0] model_check(cmd_s c);
    if (c.typ == 2'd3) return 3'd2;
    if (!c.halted) return 3'd4;
    if (c.typ == 2'd0 && (c.addr < 32'h1000 || c.addr > 32'h101F)) return 3'd2;
    if (c.typ == 2'd1 && c.addr > 32'hFFF) return 3'd2;
    if (c.typ == 2'd2) begin
      if (c.size == 2'd3) return 3'd3;
      if (c.size == 2'd1 && (c.addr % 2) != 0) return 3'd3;
      if (c.size == 2'd2 && (c.addr % 4) != 0) return 3'd3;
    end
    return 3'd0;
  endfunction

  function automatic rsp_s model_rsp(cmd_s c);
    rsp_s       r;
    logic [2:0] e;
    bit         timed_out;
    e = model_check(c);
    r.rdata  = 32'd0;
    r.cmderr = e;
    if (e == 3'd0) begin
      timed_out = (c.kind == K_NONE);
`ifdef DBG_CMD_TIMEOUT_EN
      if (c.delay >= TB_TIMEOUT) timed_out = 1'b1;
`endif
      if (timed_out || c.kind == K_FAIL || c.kind == K_BOTH) begin
        r.cmderr = 3'd3;
      end else begin
        r.rdata = c.write ? 32'd0 : c.rddata;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] out_vec();
    return {bus.req_ready, bus.dbg_cmd_valid, bus.dbg_cmd_write, bus.dbg_cmd_type,
            bus.dbg_cmd_addr, bus.dbg_cmd_wrdata, bus.dbg_cmd_size,
            bus.rsp_valid, bus.rsp_cmderr, bus.rsp_rdata};
  endfunction

  // Present one request; expectations are queued before it is accepted
  task automatic send_req(cmd_s c, bit expect_rsp);
    int n;
    n = 0;
    while (!bus.req_ready) begin
      @(negedge clk);
      n++;
      if (n > 200) abort_run("req_ready wait");
    end
    if (model_check(c) == 3'd0) issue_q.push_back(c);
    if (expect_rsp) begin
      rsp_q.push_back(model_rsp(c));
      rsp_pushed++;
    end
    bus.core_halted = c.halted;
    bus.req_valid   = 1'b1;
    bus.req_write   = c.write;
    bus.req_type    = c.typ;
    bus.req_addr    = c.addr;
    bus.req_wdata   = c.wdata;
    bus.req_size    = c.size;
    @(negedge clk);
    bus.req_valid   = 1'b0;
    bus.req_addr    = $urandom;
    bus.req_type    = 2'($urandom_range(0, 3));
  endtask

  task automatic run_cmd(cmd_s c);
    int n;
    send_req(c, 1'b1);
    @(negedge clk);
    // CHECK has already sampled core_halted; dropping it now must not abort
    if (c.drop_halt) bus.core_halted = 1'b0;
    n = 0;
    while (rsp_seen != rsp_pushed || core_busy) begin
      @(negedge clk);
      n++;
      if (n > 400) abort_run("response wait");
    end
  endtask

  function automatic cmd_s mk(logic w, logic [1:0] t, logic [31:0] a, logic [31:0] d,
                              logic [1:0] s, logic h, int k, int dl, logic [31:0] rd);
    cmd_s c;
    c.write = w; c.typ = t; c.addr = a; c.wdata = d; c.size = s; c.halted = h;
    c.kind = k; c.delay = dl; c.rddata = rd; c.drop_halt = 1'b0;
    return c;
  endfunction

  function automatic cmd_s rand_cmd();
    cmd_s        c;
    int          sel;
    logic [31:0] a;
    sel = int'($urandom_range(0, 9));
    c.typ = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
    a = $urandom;
    if (c.typ == 2'd0) begin
      if ($urandom_range(0, 7) != 0) a = 32'h1000 + 32'($urandom_range(0, 35));
    end else if (c.typ == 2'd1) begin
      if ($urandom_range(0, 5) != 0) a = 32'($urandom_range(0, 32'hFFF));
    end else if ($urandom_range(0, 1) == 0) begin
      a[1:0] = 2'b00;
    end
    c.addr      = a;
    c.size      = ($urandom_range(0, 7) == 7) ? 2'd3 : 2'($urandom_range(0, 2));
    c.write     = 1'($urandom_range(0, 1));
    c.wdata     = $urandom;
    c.halted    = ($urandom_range(0, 7) != 0);
    c.rddata    = $urandom;
    sel         = int'($urandom_range(0, 5));
    c.kind      = (sel < 4) ? K_DONE : (sel == 4) ? K_FAIL : K_BOTH;
`ifdef DBG_CMD_TIMEOUT_EN
    c.delay     = int'($urandom_range(0, 10));
    if ($urandom_range(0, 9) == 0) c.kind = K_NONE;
`else
    c.delay     = int'($urandom_range(0, 6));
`endif
    c.drop_halt = ($urandom_range(0, 3) == 0);
    return c;
  endfunction

  // Core model: checks each issued command, then answers with done/fail
  initial begin
    cmd_s e;
    logic [31:0] exp_addr;
    core_busy        = 1'b0;
    bus.dbg_cmd_done = 1'b0;
    bus.dbg_cmd_fail = 1'b0;
    bus.dbg_rddata   = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst && bus.dbg_cmd_valid) begin
        if (issue_q.size() == 0) begin
          check("unexpected dbg_cmd_valid", 1, 0);
        end else begin
          core_busy = 1'b1;
          e = issue_q.pop_front();
          exp_addr = (e.typ == 2'd0) ? e.addr - 32'h1000 : e.addr;
          check("dbg_cmd fields",
                {bus.dbg_cmd_write, bus.dbg_cmd_type, bus.dbg_cmd_addr, bus.dbg_cmd_wrdata, bus.dbg_cmd_size},
                {e.write, e.typ, exp_addr, e.wdata, e.size});
          @(negedge clk);
          check("dbg_cmd_valid single pulse", bus.dbg_cmd_valid, 0);
          check("dbg_cmd held in wait",
                {bus.dbg_cmd_write, bus.dbg_cmd_type, bus.dbg_cmd_wrdata, bus.dbg_cmd_size},
                {e.write, e.typ, e.wdata, e.size});
          if (e.kind != K_NONE) begin
            repeat (e.delay) @(negedge clk);
            bus.dbg_cmd_done = (e.kind == K_DONE) || (e.kind == K_BOTH);
            bus.dbg_cmd_fail = (e.kind == K_FAIL) || (e.kind == K_BOTH);
            bus.dbg_rddata   = e.rddata;
            @(negedge clk);
            bus.dbg_cmd_done = 1'b0;
            bus.dbg_cmd_fail = 1'b0;
            bus.dbg_rddata   = $urandom;
          end
          core_busy = 1'b0;
        end
      end
    end
  end

  // Response monitor: owns rsp_ready, applies random or long backpressure
  initial begin
    int   stall;
    logic post_hs;
    rsp_s exp;
    bus.rsp_ready = 1'b0;
    stall   = -1;
    post_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (post_hs) begin
        check("after handshake rsp_valid/req_ready", {bus.rsp_valid, bus.req_ready}, 2'b01);
        post_hs       = 1'b0;
        bus.rsp_ready = 1'b0;
      end
      if (!rst && bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected rsp_valid", 1, 0);
          bus.rsp_ready = 1'b1;
          post_hs       = 1'b1;
        end else begin
          if (stall < 0) stall = force_stall ? 10 : int'($urandom_range(0, 2));
          exp = rsp_q[0];
          check("rsp cmderr/rdata", {bus.rsp_cmderr, bus.rsp_rdata}, {exp.cmderr, exp.rdata});
          check("req_ready low in resp", bus.req_ready, 0);
          if (stall == 0) begin
            bus.rsp_ready = 1'b1;
            void'(rsp_q.pop_front());
            rsp_seen++;
            post_hs = 1'b1;
            stall   = -1;
          end else begin
            stall--;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    cmd_s c;
    total = 0; bad = 0; rsp_pushed = 0; rsp_seen = 0;
    force_stall   = 1'b0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_type  = 2'd0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_size  = 2'd0;
    bus.core_halted = 1'b1;
    repeat (2) @(negedge clk);
    check("reset outputs", out_vec(), {1'b1, 106'd0});
    rst = 1'b0;
    @(negedge clk);
    check("idle outputs", out_vec(), {1'b1, 106'd0});

    run_cmd(mk(0, 2'd0, 32'h1005, 32'h0, 2'd0, 1, K_DONE, 0, 32'hDEADBEEF));
    run_cmd(mk(1, 2'd1, 32'h7C4, 32'h3, 2'd0, 1, K_BOTH, 1, 32'h12345678));
    run_cmd(mk(0, 2'd1, 32'h300, 32'h0, 2'd0, 0, K_DONE, 0, 32'h1));
    run_cmd(mk(0, 2'd3, 32'h1005, 32'h0, 2'd0, 1, K_DONE, 0, 32'h1));
    run_cmd(mk(0, 2'd0, 32'h2000, 32'h0, 2'd0, 1, K_DONE, 0, 32'h1));
    run_cmd(mk(0, 2'd2, 32'h1002, 32'h0, 2'd2, 1, K_DONE, 0, 32'h1));
    run_cmd(mk(0, 2'd2, 32'h1002, 32'h0, 2'd1, 1, K_DONE, 2, 32'hA5A5_0001));
    run_cmd(mk(1, 2'd2, 32'h1003, 32'hFF, 2'd0, 1, K_DONE, 3, 32'hCAFE_0000));
    run_cmd(mk(0, 2'd0, 32'h101F, 32'h0, 2'd0, 1, K_FAIL, 0, 32'h5));

    c = mk(0, 2'd0, 32'h1011, 32'h0, 2'd0, 1, K_DONE, 2, 32'h0BAD_F00D);
    c.drop_halt = 1'b1;
    force_stall = 1'b1;
    run_cmd(c);
    force_stall = 1'b0;

`ifdef DBG_CMD_TIMEOUT_EN
    run_cmd(mk(0, 2'd1, 32'h7B0, 32'h0, 2'd0, 1, K_DONE, TB_TIMEOUT + 2, 32'h77));
    run_cmd(mk(0, 2'd1, 32'h7B0, 32'h0, 2'd0, 1, K_NONE, 0, 32'h77));
    run_cmd(mk(0, 2'd1, 32'h7B0, 32'h0, 2'd0, 1, K_DONE, TB_TIMEOUT - 1, 32'h88));
`endif

    for (int i = 0; i < 80; i++) begin
      force_stall = ($urandom_range(0, 9) == 0);
      run_cmd(rand_cmd());
    end
    force_stall = 1'b0;

    // Reset while the command sits in WAIT: no response may follow
    send_req(mk(1, 2'd0, 32'h1003, 32'h55, 2'd0, 1, K_NONE, 0, 32'h0), 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset in wait outputs", out_vec(), {1'b1, 106'd0});
    @(negedge clk);
    check("reset held outputs", out_vec(), {1'b1, 106'd0});
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no response after reset", {bus.rsp_valid, bus.req_ready}, 2'b01);

    run_cmd(mk(0, 2'd0, 32'h1001, 32'h0, 2'd0, 1, K_DONE, 0, 32'h1357_9BDF));
    repeat (5) @(negedge clk);
    check("rsp queue drained", 32'(rsp_q.size()), 32'd0);
    check("issue queue drained", 32'(issue_q.size()), 32'd0);
    finish_run();
  end

endmodule
`default_nettype wire

// File: doc/el2_dbg_cmd_issue.md
Name: el2_dbg_cmd_issue

Overview:
Initiator side of the debug-command interface consumed by the decode instruction-buffer.
- Accepts one abstract command at a time from the debug-module register front end.
- Validates the command against core halt state and the address/size rules below.
- Drives a single-cycle dbg_cmd_* pulse into decode, then waits for done/fail from the core.
- Returns a status code and read data to the front end on a valid/ready response channel.

Parameters:
TIMEOUT_CYCLES, 255, cycles to wait in WAIT for done/fail before declaring failure.
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, not overridden).

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  front-end command valid
req_ready  out  1  block can accept a command
req_write  in  1  1 = write, 0 = read
req_type  in  2  0 GPR, 1 CSR, 2 memory, 3 reserved
req_addr  in  32  regno (GPR/CSR) or memory address
req_wdata  in  32  write data
req_size  in  2  memory access size: 0 byte, 1 half, 2 word
core_halted  in  1  core is in debug halt
dbg_cmd_valid  out  1  command pulse to decode
dbg_cmd_write  out  1  command is write
dbg_cmd_type  out  2  command type
dbg_cmd_addr  out  32  GPR index in [4:0], CSR in [11:0], or memory address
dbg_cmd_wrdata  out  32  write data
dbg_cmd_size  out  2  memory size
dbg_cmd_done  in  1  core completed command
dbg_cmd_fail  in  1  core reports exception
dbg_rddata  in  32  read data, valid with done
rsp_valid  out  1  response valid
rsp_ready  in  1  front end accepts response
rsp_cmderr  out  3  0 none, 2 unsupported, 3 exception, 4 halt/resume
rsp_rdata  out  32  captured read data

Behaviour:
- Reset values:
  - All outputs 0, except req_ready = 1.
  - State IDLE; counter 0.
  - Capture registers (command and read data) cleared to 0.
- FSM states: IDLE, CHECK, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: register write/type/addr/wdata/size and go to CHECK.
  - req_ready is 0 in every other state.
- CHECK (one cycle). Checks in priority order:
  1. type == 3 → cmderr 2.
  2. ~core_halted → cmderr 4.
  3. type 0 with req_addr[31:5] != 27'h80 (regno outside 0x1000–0x101F) → cmderr 2.
  4. type 1 with addr[31:12] != 0 → cmderr 2.
  5. type 2 with size == 3, or misaligned (half with addr[0] set; word with addr[1:0] != 0) → cmderr 3.
  - Any error: go to RESP without pulsing dbg_cmd_valid.
  - Otherwise go to ISSUE.
- ISSUE (one cycle):
  - dbg_cmd_valid = 1 for exactly this cycle.
  - GPR commands drive dbg_cmd_addr = {27'b0, regno[4:0]}; all other types drive the address unchanged.
  - dbg_cmd_write/type/wrdata/size are held stable from ISSUE through the end of WAIT.
  - Clear counter; go to WAIT.
- WAIT:
  - dbg_cmd_fail → cmderr 3 (fail wins if it arrives together with done).
  - Else dbg_cmd_done → cmderr 0; capture dbg_rddata for reads, 0 for writes.
  - Either event → RESP.
  - Counter increments every WAIT cycle.
- RESP:
  - rsp_valid = 1; rsp_cmderr and rsp_rdata held stable.
  - On rsp_ready → IDLE, rsp_valid drops the next cycle.
  - rsp_rdata is 0 on any error.
- done/fail are ignored outside WAIT; no queuing.
- core_halted dropping during WAIT does not abort the command; the block still waits for done/fail/timeout.
- Reset asserted mid-operation: immediate return to IDLE; no response is produced.
- Back-to-back commands: minimum 5 cycles from req accept to rsp_valid with done in the first WAIT cycle. A new request is accepted the cycle after the RESP handshake.

Optional Feature:
DBG_CMD_TIMEOUT_EN.
- Defined: in WAIT, when counter == TIMEOUT_CYCLES-1 and neither done nor fail is present → cmderr 3, go to RESP. Any done/fail arriving later is ignored.
- Undefined: counter logic is removed; WAIT exits only on done/fail.

Decomposition:
- Shared package el2_dbg_pkg holds:
  - el2_dbg_cmd_state_t enum.
  - Cmderr localparams CMDERR_NONE/UNSUP/EXCEPT/HALT.
  - Type localparams DBG_TYPE_GPR/CSR/MEM.
  - GPR_REGNO_BASE = 32'h1000.
- One natural sub-module: el2_dbg_cmd_check, the combinational validator producing error flag and cmderr from the captured command and core_halted.

Test Plan:
- GPR read: halted, req type 0, addr 0x1005, write 0 → one-cycle dbg_cmd_valid with dbg_cmd_addr 0x5; core done with rddata 0xDEADBEEF → rsp cmderr 0, rdata 0xDEADBEEF.
- CSR write fail: type 1, addr 0x7C4, wdata 0x3, write 1; core asserts done and fail in the same cycle → rsp cmderr 3, rdata 0.
- Not halted: core_halted 0, type 1 → no dbg_cmd_valid; rsp cmderr 4 three cycles after accept.
- Illegal encodings: type 3 → cmderr 2; type 0 addr 0x2000 → cmderr 2; type 2 size 2 addr 0x1002 → cmderr 3. None pulses dbg_cmd_valid.
- Timeout (macro on, TIMEOUT_CYCLES 8): no done → rsp cmderr 3 after 8 WAIT cycles; a late done is ignored; next command is accepted normally.
- Reset during WAIT, plus response backpressure:
  - Reset in WAIT → all outputs 0, req_ready 1.
  - Hold rsp_ready 0 for 10 cycles → rsp fields stable and req_ready stays 0 throughout.
